// File: rtl/pe_row_collector_pkg.sv
// Shared constants for the PE row collector: parameter defaults
// and the controller state encoding.
package pe_row_collector_pkg;

    localparam int N_PE_DEF    = 8;
    localparam int W_DEF       = 32;
    localparam int TIMEOUT_DEF = 255;
    localparam int CNT_W       = 8;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RUN     = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_DRAIN   = 3'd3;
    localparam logic [2:0] S_CLEAR   = 3'd4;

endpackage

// File: rtl/pe_row_collector.sv
// Runs one PE array row, snapshots its results and streams them
// out word by word over a valid/ready port.
module pe_row_collector
    import pe_row_collector_pkg::*;
#(
    parameter int N_PE    = N_PE_DEF,
    parameter int W       = W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            pe_en,
    input  logic [N_PE*W-1:0] c_in,
    input  logic [N_PE-1:0] fin_in,
    output logic [W-1:0]    out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_last,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam int IW = (N_PE > 1) ? $clog2(N_PE) : 1;
    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
    localparam logic [IW-1:0] LAST = IW'(N_PE - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             fin_q, fin_d;
    logic             err_q, err_d;
    logic             done_q, done_d;
    logic             cap;
    logic [W-1:0]     buf_q [N_PE];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        fin_d   = fin_q;
        err_d   = err_q;
        done_d  = 1'b0;
        cap     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    fin_d   = 1'b0;
                    err_d   = 1'b0;
                end
            end
            S_RUN: begin
                // fin_q is the registered detect of all PEs finished
                cnt_d = cnt_q + CNT_W'(1);
                fin_d = &fin_in;
                if (fin_q) begin
                    state_d = S_CAPTURE;
                end else if (cnt_d == TMO && !(&fin_in)) begin
                    err_d   = 1'b1;
                    state_d = S_CLEAR;
                end
            end
            S_CAPTURE: begin
                cap     = 1'b1;
                idx_d   = '0;
                state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (out_ready) begin
                    if (idx_q == LAST) begin
                        idx_d   = '0;
                        state_d = S_CLEAR;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            S_CLEAR: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            fin_q   <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            fin_q   <= fin_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < N_PE; k++) buf_q[k] <= '0;
        end else if (cap) begin
            for (int k = 0; k < N_PE; k++) buf_q[k] <= c_in[k*W +: W];
        end
    end

    assign pe_en     = (state_q == S_RUN) || (state_q == S_CAPTURE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DRAIN);
    assign out_last  = out_valid && (idx_q == LAST);
    assign out_data  = out_valid ? buf_q[idx_q] : '0;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_pe_row_collector.sv
// Directed bench for pe_row_collector: nominal row, stalls,
// timeout, mid-drain reset, ignored starts and lane extremes.
module tb_pe_row_collector;

    localparam int N  = 8;
    localparam int WW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          pe_en;
    logic [N*WW-1:0] c_in;
    logic [N-1:0]  fin_in;
    logic [WW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;
    logic          done;
    logic          err;

    int errors = 0;
    int checks = 0;

    logic [WW-1:0] exp_w [N];
    logic [WW-1:0] got [16];
    int ngot, ndone, lastpos, viol;

    always #5 clk = ~clk;

    pe_row_collector #(.N_PE(N), .W(WW), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .start(start), .pe_en(pe_en),
        .c_in(c_in), .fin_in(fin_in), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .done(done), .err(err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_cin();
        for (int k = 0; k < N; k++) c_in[k*WW +: WW] = exp_w[k];
    endtask

    // Pulses start, finishes the PEs at RUN cycle fin_cyc and
    // returns the cycle index at which out_valid first rises.
    task automatic go_to_drain(input int fin_cyc, input int again,
                               output int lat, output int pe_bad);
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        pe_bad = 0;
        while (!out_valid && lat < 400) begin
            if (pe_en !== 1'b1) pe_bad++;
            if (lat == fin_cyc) fin_in = '1;
            start = (lat == again);
            tick();
            lat++;
        end
        start = 1'b0;
        fin_in = '0;
        c_in = {N{32'hDEAD_BEEF}};
    endtask

    task automatic drain_collect(input int mode, input int start_at);
        logic hold;
        logic [WW-1:0] held;
        hold = 1'b0;
        held = '0;
        ngot = 0;
        ndone = 0;
        lastpos = -1;
        viol = 0;
        for (int t = 0; t < 40; t++) begin
            out_ready = (mode == 0) || (t % 4 == 0) || (t % 4 == 3);
            start = (t == start_at);
            if (hold && out_valid && out_data !== held) viol++;
            hold = 1'b0;
            if (done) ndone++;
            if (out_valid && out_ready) begin
                if (ngot < 16) got[ngot] = out_data;
                if (out_last) lastpos = ngot;
                ngot++;
            end else if (out_valid) begin
                hold = 1'b1;
                held = out_data;
            end
            tick();
        end
        start = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({pe_en, out_valid, out_last, busy, done, err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctl got %b exp 000000",
                     {pe_en, out_valid, out_last, busy, done, err});
        end
        checks++;
        if (out_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_data got %h exp 0", out_data);
        end
        tick();
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle busy got %b exp 0", busy);
        end
    endtask

    task automatic test_nominal();
        int lat, pb;
        for (int k = 0; k < N; k++) exp_w[k] = k * 32'h0001_0001;
        load_cin();
        go_to_drain(65, -1, lat, pb);
        checks++;
        if (lat !== 68) begin
            errors++;
            $display("FAIL nom_latency got %0d exp 68", lat);
        end
        checks++;
        if (pb !== 0) begin
            errors++;
            $display("FAIL nom_pe_en_run bad %0d exp 0", pb);
        end
        checks++;
        if (pe_en !== 1'b0) begin
            errors++;
            $display("FAIL nom_pe_en_drain got %b exp 0", pe_en);
        end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (out_data !== exp_w[k] || out_valid !== 1'b1 ||
                out_last !== (k == N - 1)) begin
                errors++;
                $display("FAIL nom_word%0d got %h/%b/%b exp %h/1/%b",
                         k, out_data, out_valid, out_last,
                         exp_w[k], (k == N - 1));
            end
            tick();
        end
        checks++;
        if ({out_valid, pe_en, busy, done} !== 4'b0010) begin
            errors++;
            $display("FAIL nom_clear got %b exp 0010",
                     {out_valid, pe_en, busy, done});
        end
        tick();
        checks++;
        if ({busy, done} !== 2'b01) begin
            errors++;
            $display("FAIL nom_done got %b exp 01", {busy, done});
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL nom_done_pulse got %b exp 0", done);
        end
    endtask

    task automatic test_backpressure();
        int lat, pb;
        for (int k = 0; k < N; k++) exp_w[k] = 32'hC0DE_0000 | k;
        load_cin();
        go_to_drain(65, -1, lat, pb);
        drain_collect(1, -1);
        checks++;
        if (viol !== 0) begin
            errors++;
            $display("FAIL bp_stable viol %0d exp 0", viol);
        end
        checks++;
        if (ngot !== N || ndone !== 1 || lastpos !== N - 1) begin
            errors++;
            $display("FAIL bp_count got %0d/%0d/%0d exp 8/1/7",
                     ngot, ndone, lastpos);
        end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (got[k] !== exp_w[k]) begin
                errors++;
                $display("FAIL bp_word%0d got %h exp %h",
                         k, got[k], exp_w[k]);
            end
        end
    endtask

    task automatic test_timeout();
        int bad, lat, pb;
        start = 1'b1;
        tick();
        start = 1'b0;
        fin_in = 8'hF7;
        bad = 0;
        for (int c = 1; c <= 255; c++) begin
            if (pe_en !== 1'b1 || out_valid !== 1'b0 ||
                err !== 1'b0 || busy !== 1'b1) bad++;
            tick();
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL to_run bad %0d exp 0", bad);
        end
        checks++;
        if ({err, pe_en, out_valid, done, busy} !== 5'b10001) begin
            errors++;
            $display("FAIL to_clear got %b exp 10001",
                     {err, pe_en, out_valid, done, busy});
        end
        tick();
        checks++;
        if ({done, err, busy} !== 3'b110) begin
            errors++;
            $display("FAIL to_done got %b exp 110", {done, err, busy});
        end
        tick();
        checks++;
        if ({done, err} !== 2'b01) begin
            errors++;
            $display("FAIL to_sticky got %b exp 01", {done, err});
        end
        fin_in = '0;
        for (int k = 0; k < N; k++) exp_w[k] = 32'h1234_0000 + k;
        load_cin();
        go_to_drain(65, -1, lat, pb);
        checks++;
        if (err !== 1'b0 || lat !== 68) begin
            errors++;
            $display("FAIL to_restart err %b lat %0d exp 0 68", err, lat);
        end
        drain_collect(0, -1);
        checks++;
        if (ngot !== N || ndone !== 1) begin
            errors++;
            $display("FAIL to_row2 got %0d/%0d exp 8/1", ngot, ndone);
        end
    endtask

    task automatic test_reset_drain();
        int lat, pb, bad;
        for (int k = 0; k < N; k++) exp_w[k] = k * 32'h1111_1111;
        load_cin();
        go_to_drain(65, -1, lat, pb);
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_data !== exp_w[3]) begin
            errors++;
            $display("FAIL rd_pre got %h exp %h", out_data, exp_w[3]);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({pe_en, out_valid, out_last, busy, done, err} !== 6'b0 ||
            out_data !== 32'h0) begin
            errors++;
            $display("FAIL rd_async got %b/%h exp 000000/0",
                     {pe_en, out_valid, out_last, busy, done, err},
                     out_data);
        end
        tick();
        tick();
        rst = 1'b1;
        out_ready = 1'b1;
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            if (done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0)
                bad++;
            tick();
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL rd_quiet bad %0d exp 0", bad);
        end
        for (int k = 0; k < N; k++) exp_w[k] = 32'hAB00_0000 + k;
        load_cin();
        go_to_drain(65, -1, lat, pb);
        drain_collect(0, -1);
        checks++;
        if (lat !== 68 || ngot !== N || ndone !== 1 ||
            got[0] !== exp_w[0] || got[7] !== exp_w[7]) begin
            errors++;
            $display("FAIL rd_row got %0d/%0d/%0d/%h/%h exp 68/8/1/%h/%h",
                     lat, ngot, ndone, got[0], got[7],
                     exp_w[0], exp_w[7]);
        end
    endtask

    task automatic test_start_ignored();
        int lat, pb;
        for (int k = 0; k < N; k++) exp_w[k] = 32'h0F0F_0000 + k * 3;
        load_cin();
        go_to_drain(65, 30, lat, pb);
        checks++;
        if (lat !== 68) begin
            errors++;
            $display("FAIL si_latency got %0d exp 68", lat);
        end
        drain_collect(0, 2);
        checks++;
        if (ngot !== N || ndone !== 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL si_count got %0d/%0d/%b exp 8/1/0",
                     ngot, ndone, busy);
        end
        checks++;
        if (got[5] !== exp_w[5]) begin
            errors++;
            $display("FAIL si_order got %h exp %h", got[5], exp_w[5]);
        end
    endtask

    task automatic test_lanes();
        int lat, pb;
        for (int k = 0; k < N; k++)
            exp_w[k] = (k % 2 == 0) ? 32'hFFFF_0000 : 32'h0000_FFFF;
        exp_w[7] = 32'hFFFF_FFFF;
        load_cin();
        go_to_drain(65, -1, lat, pb);
        drain_collect(0, -1);
        for (int k = 0; k < N; k++) begin
            checks++;
            if (got[k] !== exp_w[k]) begin
                errors++;
                $display("FAIL lane_word%0d got %h exp %h",
                         k, got[k], exp_w[k]);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        c_in = '0;
        fin_in = '0;
        out_ready = 1'b1;
        test_reset();
        test_nominal();
        test_backpressure();
        test_timeout();
        test_reset_drain();
        test_start_ignored();
        test_lanes();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
